// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the MMIO UART transmitter.
//   tx_state_t      transmitter FSM states (PARITY used only with UART_TX_PARITY_EN)
//   UART_DATA_BITS  data bits per frame
//   baud_div()      cycles per bit for a given clock and line rate
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Integer clock cycles per serial bit
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_mmio_tx_if.sv
// uart_mmio_tx_if: MMIO write channel from the Memory stage to the UART transmitter.
//   mmio_wea   write strobe, one byte per asserted cycle
//   mmio_dat   write data, low byte transmitted
//   mmio_read  back-pressure, 1 = a write can be accepted this cycle
// Modports: master (core side), slave (transmitter side).
interface uart_mmio_tx_if;

    logic        mmio_wea;
    logic [31:0] mmio_dat;
    logic        mmio_read;

    modport master (output mmio_wea, output mmio_dat, input mmio_read);
    modport slave  (input mmio_wea, input mmio_dat, output mmio_read);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with registered pointers and count.
//   clk, Rst     clock, synchronous active-high reset (empties the FIFO)
//   push, din    write request and byte (ignored when full unless popping)
//   pop, dout    read request and head byte (dout valid while not empty)
//   count        occupancy, full, empty
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointer wrap comes for free from the power-of-2 pointer width
    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: MMIO-driven UART transmitter. Bytes written on the MMIO channel are
// queued in a FIFO and sent LSB-first as 8N1 frames on tx.
//   clk, Rst     clock, synchronous active-high reset
//   bus          MMIO write channel (slave): mmio_wea, mmio_dat in; mmio_read out
//   tx           serial line, idle high, registered
//   tx_busy      frame in progress or bytes queued
//   fifo_count   FIFO occupancy
//   overflow     sticky, a write was dropped while full
// Build option: define UART_TX_PARITY_EN to append an even-parity bit (8E1).
module uart_mmio_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          Rst,
    uart_mmio_tx_if.slave                 bus,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned DIV  = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned BW   = $clog2(DIV);
    localparam int unsigned BITW = $clog2(UART_DATA_BITS);

    tx_state_t                  state_q, state_d;
    logic [BW-1:0]              baud_q, baud_d;
    logic [BITW-1:0]            bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic                       ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic                       par_q, par_d;
`endif

    logic       pop;
    logic       push;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       baud_end;
    logic       unused_dat;

    assign unused_dat = ^bus.mmio_dat[31:8];

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.mmio_dat[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.mmio_read = !fifo_full;
    assign tx_busy       = (state_q != IDLE) || !fifo_empty;
    assign tx            = tx_q;
    assign overflow      = ovf_q;
    assign baud_end      = (baud_q == BW'(DIV - 1));

    // Next state, FIFO handshake and next line level
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                    state_d = START;
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BITW'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BITW'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes are queued
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^fifo_dout;
`endif
                        state_d = START;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Line level follows the upcoming state so tx is a clean flop output
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        push  = bus.mmio_wea && (!fifo_full || pop);
        ovf_d = ovf_q || (bus.mmio_wea && !push);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// tb_uart_mmio_tx: scoreboard bench for uart_mmio_tx (DIV=16, FIFO_DEPTH=8).
// A frame-level reference model predicts accepted bytes, FIFO occupancy and the line level;
// a serial decoder monitor pops expected bytes as frames appear on tx.
module tb_uart_mmio_tx;

    localparam int unsigned DIV   = 16;
    localparam int unsigned DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FRAME = NB * DIV;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       tx;
    logic       tx_busy;
    logic [3:0] fifo_count;
    logic       overflow;

    uart_mmio_tx_if bus ();

    uart_mmio_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .bus        (bus),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_cur = '0;
    int         m_timer = 0;
    logic       m_ovf = 1'b0;
    logic [7:0] exp_q[$];

    // Frame-level model: a byte leaves the queue when the line is free or its frame is ending
    initial forever begin
        bit do_pop, do_push;
        @(posedge clk);
        if (Rst) begin
            m_q.delete();
            m_timer = 0;
            m_ovf   = 1'b0;
        end else begin
            do_pop  = (m_q.size() > 0) && (m_timer <= 1);
            do_push = bus.mmio_wea && ((m_q.size() < DEPTH) || do_pop);
            if (bus.mmio_wea && !do_push) m_ovf = 1'b1;
            if (do_pop) begin
                m_cur   = m_q.pop_front();
                m_timer = FRAME;
            end else if (m_timer > 0) begin
                m_timer--;
            end
            if (do_push) begin
                m_q.push_back(bus.mmio_dat[7:0]);
                exp_q.push_back(bus.mmio_dat[7:0]);
            end
        end
    end

    // Monitor: per-cycle output check plus serial decode against the scoreboard
    int         cyc = 0;
    int         p = 0;
    bit         mon_active = 1'b0;
    int         last_start = 0;
    int         prev_start = 0;
    int         frames = 0;
    logic [7:0] rx_byte = '0;

    initial forever begin
        logic etx;
        int   e, b, idx;
        logic [7:0] eb;
        @(negedge clk);
        cyc++;
        if (m_timer == 0) begin
            etx = 1'b1;
        end else begin
            e = FRAME - m_timer;
            b = e / DIV;
            if (b == 0)                     etx = 1'b0;
            else if (b <= 8)                etx = m_cur[b-1];
            else if (NB == 11 && b == 9)    etx = ^m_cur;
            else                            etx = 1'b1;
        end
        chk("cycle_outputs", {24'd0, tx, bus.mmio_read, tx_busy, overflow, fifo_count},
            {24'd0, etx, 1'(m_q.size() != DEPTH), 1'((m_timer > 0) || (m_q.size() > 0)),
             m_ovf, 4'(m_q.size())});

        if (Rst) begin
            mon_active = 1'b0;
            exp_q.delete();
        end else begin
            if (mon_active) begin
                p++;
            end else if (tx == 1'b0) begin
                mon_active = 1'b1;
                p          = 0;
                prev_start = last_start;
                last_start = cyc;
            end
            if (mon_active && (p % DIV == DIV / 2)) begin
                idx = p / DIV;
                if (idx == 0) begin
                    chk("rx_start_bit", {31'd0, tx}, 32'd0);
                end else if (idx <= 8) begin
                    rx_byte[idx-1] = tx;
                end else if (idx < NB - 1) begin
                    chk("rx_parity_bit", {31'd0, tx}, {31'd0, ^rx_byte});
                end else begin
                    chk("rx_stop_bit", {31'd0, tx}, 32'd1);
                    chk("rx_expected_pending", {31'd0, 1'(exp_q.size() != 0)}, 32'd1);
                    if (exp_q.size() != 0) begin
                        eb = exp_q.pop_front();
                        chk("rx_byte", {24'd0, rx_byte}, {24'd0, eb});
                    end
                    frames++;
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] d);
        bus.mmio_wea = we;
        bus.mmio_dat = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.mmio_wea = 1'b0;
        while ((tx_busy || mon_active) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'd0, 1'(n < 20000)}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned lim [3] = '{3, 20, 300};
        bus.mmio_wea = 1'b0;
        bus.mmio_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_mmio_read", {31'd0, bus.mmio_read}, 32'd1);
        chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        Rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Idle write: tx falls two cycles after the write cycle
        drive(1'b1, 32'h0000_0055);
        bus.mmio_wea = 1'b0;
        chk("lat_tx_n1", {31'd0, tx}, 32'd1);
        chk("lat_count_n1", {28'd0, fifo_count}, 32'd1);
        @(posedge clk);
        #1;
        chk("lat_tx_n2", {31'd0, tx}, 32'd0);
        chk("lat_count_n2", {28'd0, fifo_count}, 32'd0);
        chk("lat_busy_n2", {31'd0, tx_busy}, 32'd1);
        wait_idle();

        // Upper data bits ignored
        drive(1'b1, 32'hDEAD_BE41);
        wait_idle();

        // Back-to-back frames share no idle cycle
        drive(1'b1, 32'h0000_00A1);
        drive(1'b1, 32'h0000_005E);
        wait_idle();
        chk("b2b_start_spacing", 32'(last_start - prev_start), FRAME);

        // Ten consecutive writes: nine accepted, tenth dropped
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h0000_0030 + 32'(i));
        bus.mmio_wea = 1'b0;
        chk("fill_count", {28'd0, fifo_count}, 32'd8);
        chk("fill_mmio_read", {31'd0, bus.mmio_read}, 32'd0);
        chk("fill_overflow", {31'd0, overflow}, 32'd1);
        wait_idle();
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Reset in the middle of a data bit discards everything
        drive(1'b1, 32'h0000_003C);
        drive(1'b1, 32'h0000_0011);
        drive(1'b1, 32'h0000_0022);
        bus.mmio_wea = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        Rst = 1'b1;
        @(posedge clk);
        #1;
        Rst = 1'b0;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_count", {28'd0, fifo_count}, 32'd0);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        drive(1'b1, 32'h0000_00A5);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        drive(1'b1, 32'h0000_0007);
        drive(1'b1, 32'h0000_0003);
        wait_idle();
`endif

        // Randomized traffic at light, moderate and saturating write rates
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                drive(1'($urandom_range(0, 999) < lim[ph]), $urandom());
            end
        end
        wait_idle();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("frames_decoded", {31'd0, 1'(frames > 10)}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
